// File: rtl/watch_ctrl_pkg.sv
// Shared definitions for the watch control block: FSM encoding,
// digit-select one-hot constants and default cycle counts.
package watch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_SEC  = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_HOUR = 2'd3
  } state_e;

  localparam logic [2:0] DIG_NONE = 3'b000;
  localparam logic [2:0] DIG_SEC  = 3'b001;
  localparam logic [2:0] DIG_MIN  = 3'b010;
  localparam logic [2:0] DIG_HOUR = 3'b100;

  localparam int unsigned HOLD_CYC_DEF    = 50_000_000;
  localparam int unsigned RPT_CYC_DEF     = 10_000_000;
  localparam int unsigned BLINK_CYC_DEF   = 25_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000_000;

  // Field select shown for a given state.
  function automatic logic [2:0] digit_of(input state_e s);
    case (s)
      ST_SET_SEC:  return DIG_SEC;
      ST_SET_MIN:  return DIG_MIN;
      ST_SET_HOUR: return DIG_HOUR;
      default:     return DIG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/watch_ctrl_btn_repeat.sv
// Hold/auto-repeat pulse generator for one level button: one pulse on the
// rising edge, a repeat after HOLD_CYC held cycles, then every RPT_CYC cycles.
module btn_repeat #(
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned RPT_CYC  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pulse,
  output logic o_pulse_nxt_c
);

  localparam int unsigned MAXC = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic          r_prev;
  logic          r_act;
  logic          r_rpt;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  logic          w_act_nxt;
  logic          w_rpt_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Next hold/repeat counter state and pulse decision.
  always_comb begin
    w_act_nxt     = r_act;
    w_rpt_nxt     = r_rpt;
    w_cnt_nxt     = r_cnt;
    o_pulse_nxt_c = 1'b0;
    if (!i_en || i_clr || !i_level) begin
      w_act_nxt = 1'b0;
      w_rpt_nxt = 1'b0;
      w_cnt_nxt = '0;
    end else if (!r_prev) begin
      w_act_nxt     = 1'b1;
      w_rpt_nxt     = 1'b0;
      w_cnt_nxt     = '0;
      o_pulse_nxt_c = 1'b1;
    end else if (r_act) begin
      if (!r_rpt && (r_cnt == CW'(HOLD_CYC - 1))) begin
        w_rpt_nxt     = 1'b1;
        w_cnt_nxt     = '0;
        o_pulse_nxt_c = 1'b1;
      end else if (r_rpt && (r_cnt == CW'(RPT_CYC - 1))) begin
        w_cnt_nxt     = '0;
        o_pulse_nxt_c = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // Level history, counter and registered pulse; prev always follows the
  // level so a button held across a clear needs a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_act   <= 1'b0;
      r_rpt   <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_act   <= w_act_nxt;
      r_rpt   <= w_rpt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= o_pulse_nxt_c;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/watch_ctrl.sv
// Watch run/set mode controller. Optional set-mode inactivity timeout is
// enabled by defining WATCH_CTRL_TIMEOUT_EN.
module watch_ctrl
  import watch_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned RPT_CYC     = RPT_CYC_DEF,
  parameter int unsigned BLINK_CYC   = BLINK_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] digit_pos,
  output logic       o_time_up,
  output logic       o_time_down,
  output logic       stop,
  output logic       set_mode,
  output logic       blink
);

  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  // Reject parameter values the counters cannot represent.
  if (HOLD_CYC < 2 || RPT_CYC < 1 || BLINK_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("watch_ctrl: cycle parameters out of range");
  end

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_chg;
  logic          w_adj_en;
  logic          w_up_nxt;
  logic          w_dn_nxt;
  logic          r_bph;
  logic [BW-1:0] r_bcnt;
  logic          w_bph_nxt;
  logic [BW-1:0] w_bcnt_nxt;
  logic          w_blink_nxt;
  logic [2:0]    r_digit_pos;
  logic          r_stop;
  logic          r_set_mode;
  logic          r_blink;

`ifdef WATCH_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] r_tmo;
  logic          r_up_prev;
  logic          r_dn_prev;
  logic          w_idle;

  assign w_idle = !(btn_mode || btn_sel || (btn_up && !r_up_prev) || (btn_down && !r_dn_prev));

  // Consecutive idle set-mode cycles; cleared by any event or state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo     <= '0;
      r_up_prev <= 1'b0;
      r_dn_prev <= 1'b0;
    end else begin
      r_up_prev <= btn_up;
      r_dn_prev <= btn_down;
      if ((w_state_nxt == ST_RUN) || !w_idle || w_chg) r_tmo <= '0;
      else                                               r_tmo <= r_tmo + TW'(1);
    end
  end
`endif

  // Next-state logic; mode has priority over select.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (btn_mode) w_state_nxt = ST_SET_SEC;
      ST_SET_SEC:  if (btn_mode) w_state_nxt = ST_RUN; else if (btn_sel) w_state_nxt = ST_SET_MIN;
      ST_SET_MIN:  if (btn_mode) w_state_nxt = ST_RUN; else if (btn_sel) w_state_nxt = ST_SET_HOUR;
      ST_SET_HOUR: if (btn_mode) w_state_nxt = ST_RUN; else if (btn_sel) w_state_nxt = ST_SET_SEC;
      default:     w_state_nxt = ST_RUN;
    endcase
`ifdef WATCH_CTRL_TIMEOUT_EN
    if ((r_state != ST_RUN) && w_idle && (r_tmo == TW'(TIMEOUT_CYC - 1))) w_state_nxt = ST_RUN;
`endif
    w_chg = (w_state_nxt != r_state);
  end

  assign w_adj_en = (r_state != ST_RUN) && !(btn_up && btn_down);

  btn_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_rpt_up (
    .clk          (clk),
    .rst          (rst),
    .i_level      (btn_up),
    .i_en         (w_adj_en),
    .i_clr        (w_chg),
    .o_pulse      (o_time_up),
    .o_pulse_nxt_c(w_up_nxt)
  );

  btn_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)) u_rpt_dn (
    .clk          (clk),
    .rst          (rst),
    .i_level      (btn_down),
    .i_en         (w_adj_en),
    .i_clr        (w_chg),
    .o_pulse      (o_time_down),
    .o_pulse_nxt_c(w_dn_nxt)
  );

  // Blink phase: restarts high on entry/digit change, forced high on adjust.
  always_comb begin
    w_bph_nxt  = r_bph;
    w_bcnt_nxt = r_bcnt;
    if ((w_state_nxt == ST_RUN) || w_chg) begin
      w_bph_nxt  = 1'b1;
      w_bcnt_nxt = '0;
    end else if (r_bcnt == BW'(BLINK_CYC - 1)) begin
      w_bph_nxt  = ~r_bph;
      w_bcnt_nxt = '0;
    end else begin
      w_bcnt_nxt = r_bcnt + BW'(1);
    end
    w_blink_nxt = (w_state_nxt == ST_RUN) || w_bph_nxt || w_up_nxt || w_dn_nxt;
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_bph       <= 1'b1;
      r_bcnt      <= '0;
      r_digit_pos <= DIG_NONE;
      r_stop      <= 1'b0;
      r_set_mode  <= 1'b0;
      r_blink     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_bph       <= w_bph_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_digit_pos <= digit_of(w_state_nxt);
      r_stop      <= (w_state_nxt != ST_RUN);
      r_set_mode  <= (w_state_nxt != ST_RUN);
      r_blink     <= w_blink_nxt;
    end
  end

  assign digit_pos = r_digit_pos;
  assign stop      = r_stop;
  assign set_mode  = r_set_mode;
  assign blink     = r_blink;

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed bench for watch_ctrl with a pulse-timing scoreboard.
module tb_watch_ctrl;

  localparam int unsigned HOLD    = 8;
  localparam int unsigned RPT     = 4;
  localparam int unsigned BLINKC  = 3;
  localparam int unsigned TMO     = 20;
  localparam int          HOLDLEN = 20;

  logic       clk = 1'b0;
  logic       rst, btn_mode, btn_sel, btn_up, btn_down;
  logic [2:0] digit_pos;
  logic       o_time_up, o_time_down, stop, set_mode, blink;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  watch_ctrl #(
    .HOLD_CYC(HOLD), .RPT_CYC(RPT), .BLINK_CYC(BLINKC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_sel(btn_sel),
    .btn_up(btn_up), .btn_down(btn_down), .digit_pos(digit_pos),
    .o_time_up(o_time_up), .o_time_down(o_time_down), .stop(stop),
    .set_mode(set_mode), .blink(blink)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
  endtask

  task automatic pulse_sel();
    btn_sel = 1'b1; tick(); btn_sel = 1'b0;
  endtask

  // Navigate to SET_SEC from wherever the block currently is.
  task automatic to_sec();
    if (set_mode !== 1'b1) pulse_mode();
    for (int i = 0; i < 3 && digit_pos !== 3'b001; i++) pulse_sel();
  endtask

  initial begin
    int np;
    int exp_blink[6];
    exp_blink = '{1, 1, 0, 0, 0, 1};
    rst = 1'b0; btn_mode = 1'b0; btn_sel = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick(); tick();
    chk("rst_digit", 32'(digit_pos), 32'h0);
    chk("rst_up", 32'(o_time_up), 32'h0);
    chk("rst_dn", 32'(o_time_down), 32'h0);
    chk("rst_stop", 32'(stop), 32'h0);
    chk("rst_setmode", 32'(set_mode), 32'h0);
    chk("rst_blink", 32'(blink), 32'h1);
    rst = 1'b1;
    tick();

    // Up held in RUN: no pulses.
    np = 0;
    btn_up = 1'b1;
    for (int j = 0; j < 20; j++) begin tick(); np += int'(o_time_up) + int'(o_time_down); end
    btn_up = 1'b0; tick();
    chk("run_up_pulses", 32'(np), 32'h0);
    chk("run_blink", 32'(blink), 32'h1);

    // Enter set mode.
    pulse_mode();
    chk("enter_digit", 32'(digit_pos), 32'h1);
    chk("enter_stop", 32'(stop), 32'h1);
    chk("enter_setmode", 32'(set_mode), 32'h1);
    chk("enter_blink", 32'(blink), 32'h1);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("blink_ph%0d", j + 2), 32'(blink), 32'(exp_blink[j]));
    end

    // Select cycles sec -> min -> hour -> sec.
    pulse_sel(); chk("sel1_digit", 32'(digit_pos), 32'h2); chk("sel1_blink", 32'(blink), 32'h1);
    pulse_sel(); chk("sel2_digit", 32'(digit_pos), 32'h4);
    pulse_sel(); chk("sel3_digit", 32'(digit_pos), 32'h1);
    btn_mode = 1'b1; btn_sel = 1'b1; tick(); btn_mode = 1'b0; btn_sel = 1'b0;
    chk("prio_digit", 32'(digit_pos), 32'h0);
    chk("prio_setmode", 32'(set_mode), 32'h0);

    // Hold up: scoreboard of expected pulse cycles after the edge.
    to_sec();
    exp_q.delete();
    exp_q.push_back(1);
    for (int k = 1 + int'(HOLD); k <= HOLDLEN; k += int'(RPT)) exp_q.push_back(k);
    btn_up = 1'b1;
    for (int j = 1; j <= HOLDLEN + 6; j++) begin
      tick();
      if (j == HOLDLEN) btn_up = 1'b0;
      chk("hold_no_down", 32'(o_time_down), 32'h0);
      if (o_time_up) begin
        if (exp_q.size() == 0) chk("hold_extra_pulse", 32'(j), 32'h0);
        else chk("hold_pulse_cycle", 32'(j), 32'(exp_q.pop_front()));
        chk("hold_blink_forced", 32'(blink), 32'h1);
      end
    end
    chk("hold_pulses_left", 32'(exp_q.size()), 32'h0);

    // Both held: no pulses.
    to_sec();
    np = 0;
    btn_up = 1'b1; btn_down = 1'b1;
    for (int j = 0; j < 20; j++) begin tick(); np += int'(o_time_up) + int'(o_time_down); end
    btn_up = 1'b0; btn_down = 1'b0; tick();
    np += int'(o_time_up) + int'(o_time_down);
    chk("both_pulses", 32'(np), 32'h0);

    // Single down edge.
    to_sec();
    btn_down = 1'b1; tick();
    chk("dn_first", 32'(o_time_down), 32'h1);
    chk("dn_first_up", 32'(o_time_up), 32'h0);
    tick();
    chk("dn_second", 32'(o_time_down), 32'h0);
    btn_down = 1'b0; tick();

    // Idle in SET_MIN.
    to_sec();
    pulse_sel();
    chk("idle_min", 32'(digit_pos), 32'h2);
    for (int j = 0; j < int'(TMO) - 1; j++) tick();
    chk("idle_pre_tmo", 32'(digit_pos), 32'h2);
    tick();
`ifdef WATCH_CTRL_TIMEOUT_EN
    chk("tmo_digit", 32'(digit_pos), 32'h0);
    chk("tmo_stop", 32'(stop), 32'h0);
`else
    chk("notmo_digit", 32'(digit_pos), 32'h2);
    chk("notmo_stop", 32'(stop), 32'h1);
`endif

    // Reset during repeat in SET_HOUR.
    to_sec();
    pulse_sel(); pulse_sel();
    chk("hour_digit", 32'(digit_pos), 32'h4);
    np = 0;
    btn_up = 1'b1;
    for (int j = 1; j <= 11; j++) begin tick(); np += int'(o_time_up); end
    chk("hour_pulses", 32'(np), 32'h2);
    rst = 1'b0; tick();
    chk("mrst_digit", 32'(digit_pos), 32'h0);
    chk("mrst_up", 32'(o_time_up), 32'h0);
    chk("mrst_dn", 32'(o_time_down), 32'h0);
    chk("mrst_stop", 32'(stop), 32'h0);
    chk("mrst_setmode", 32'(set_mode), 32'h0);
    chk("mrst_blink", 32'(blink), 32'h1);
    tick();
    chk("mrst_trailing", 32'(o_time_up), 32'h0);
    rst = 1'b1;
    np = 0;
    for (int j = 0; j < 4; j++) begin tick(); np += int'(o_time_up); end
    chk("post_rst_pulses", 32'(np), 32'h0);
    chk("post_rst_digit", 32'(digit_pos), 32'h0);
    btn_up = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
